// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (jump > branch > stall > sequential)
// and the IF/ID pipeline register with one-bubble flush on redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_in,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_BRANCH,
    SEL_JUMP
  } pc_sel_e;

  pc_sel_e     pc_sel;
  logic [31:0] pc_q, pc_d, pc4;
  logic [31:0] br_target, j_target;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  assign pc4       = pc_q + 32'd4;
  assign br_target = ifid_pc4_q + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign j_target  = {ifid_pc4_q[31:28], jump_target, 2'b00};

  // Redirects come from the instruction in ID, so a bubble there can never redirect.
  always_comb begin
    pc_sel = SEL_SEQ;
    if (jump && ifid_valid_q) begin
      pc_sel = SEL_JUMP;
    end else if (branch_taken && ifid_valid_q) begin
      pc_sel = SEL_BRANCH;
    end else if (stall) begin
      pc_sel = SEL_HOLD;
    end
  end

  always_comb begin
    pc_d         = pc4;
    ifid_inst_d  = inst_in;
    ifid_pc4_d   = pc4;
    ifid_valid_d = 1'b1;
    unique case (pc_sel)
      SEL_JUMP: begin
        pc_d         = j_target;
        ifid_inst_d  = '0;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = 1'b0;
      end
      SEL_BRANCH: begin
        pc_d         = br_target;
        ifid_inst_d  = '0;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = 1'b0;
      end
      SEL_HOLD: begin
        pc_d         = pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= {RESET_PC[31:2], 2'b00};
      ifid_inst_q  <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign inst_addr  = pc_q;
  assign ifid_inst  = ifid_inst_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: expected IF/ID contents are queued as each cycle is
// driven and compared after the edge; next-PC values come from hand-derived step tables.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] inst_addr;
  logic [31:0] inst_in;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        st;
    logic        br;
    logic [15:0] off;
    logic        j;
    logic [25:0] jt;
    logic [31:0] addr;
  } step_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t sbq[$];

  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .inst_addr    (inst_addr),
    .inst_in      (inst_in),
    .ifid_inst    (ifid_inst),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign inst_in = memw(inst_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic step_t mk(input logic st, input logic br, input logic [15:0] off,
                               input logic j, input logic [25:0] jt, input logic [31:0] addr);
    step_t s;
    s.st = st; s.br = br; s.off = off; s.j = j; s.jt = jt; s.addr = addr;
    return s;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_inst = '0; m_pc4 = '0; m_valid = 1'b0;
    sbq.delete();
  endtask

  task automatic drive_cycle(input step_t s);
    logic [31:0] npc4;
    stall = s.st; branch_taken = s.br; branch_offset = s.off;
    jump = s.j; jump_target = s.jt;
    npc4 = m_pc + 32'd4;
    if (s.j && m_valid) begin
      m_pc = {m_pc4[31:28], s.jt, 2'b00}; m_inst = '0; m_valid = 1'b0;
    end else if (s.br && m_valid) begin
      m_pc = m_pc4 + {{14{s.off[15]}}, s.off, 2'b00}; m_inst = '0; m_valid = 1'b0;
    end else if (!s.st) begin
      m_inst = memw(m_pc); m_pc4 = npc4; m_valid = 1'b1; m_pc = npc4;
    end
    sbq.push_back('{m_inst, m_pc4, m_valid});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    jump = 1'b0; jump_target = '0;
    model_reset();
    #12;
    checks++;
    if (inst_addr !== RST_PC || ifid_inst !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got %h/%h/%h/%b want %h/0/0/0", inst_addr, ifid_inst, ifid_pc4, ifid_valid, RST_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    step_t s[$];
    exp_t  e;
    for (int i = 0; i < 11; i++) s.push_back(mk(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'((i + 1) * 4)));
    foreach (s[i]) begin
      drive_cycle(s[i]);
      e = sbq.pop_front();
      checks++;
      if (inst_addr !== s[i].addr) begin
        failures++; $display("FAIL seq_addr[%0d] got %h want %h", i, inst_addr, s[i].addr);
      end
      checks++;
      if (ifid_inst !== e.inst || ifid_pc4 !== e.pc4 || ifid_valid !== e.valid) begin
        failures++; $display("FAIL seq_ifid[%0d] got %h/%h/%b want %h/%h/%b", i, ifid_inst, ifid_pc4, ifid_valid, e.inst, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_branch();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(1'b0, 1'b1, 16'hFFFB, 1'b0, 26'h0, 32'h18));
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 32'h1C));
    s.push_back(mk(1'b0, 1'b1, 16'h0002, 1'b0, 26'h0, 32'h24));
    s.push_back(mk(1'b0, 1'b1, 16'h0002, 1'b0, 26'h0, 32'h28));
    foreach (s[i]) begin
      drive_cycle(s[i]);
      e = sbq.pop_front();
      checks++;
      if (inst_addr !== s[i].addr) begin
        failures++; $display("FAIL branch_addr[%0d] got %h want %h", i, inst_addr, s[i].addr);
      end
      checks++;
      if (ifid_inst !== e.inst || ifid_pc4 !== e.pc4 || ifid_valid !== e.valid) begin
        failures++; $display("FAIL branch_ifid[%0d] got %h/%h/%b want %h/%h/%b", i, ifid_inst, ifid_pc4, ifid_valid, e.inst, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_jump();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 26'h008, 32'h20));
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 26'h000, 32'h24));
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 26'h00A, 32'h28));
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 26'h000, 32'h2C));
    s.push_back(mk(1'b0, 1'b1, 16'h0002, 1'b1, 26'h010, 32'h40));
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 26'h000, 32'h44));
    foreach (s[i]) begin
      drive_cycle(s[i]);
      e = sbq.pop_front();
      checks++;
      if (inst_addr !== s[i].addr) begin
        failures++; $display("FAIL jump_addr[%0d] got %h want %h", i, inst_addr, s[i].addr);
      end
      checks++;
      if (ifid_inst !== e.inst || ifid_pc4 !== e.pc4 || ifid_valid !== e.valid) begin
        failures++; $display("FAIL jump_ifid[%0d] got %h/%h/%b want %h/%h/%b", i, ifid_inst, ifid_pc4, ifid_valid, e.inst, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_neg_wrap();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 26'h003, 32'h0000_000C));
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 26'h000, 32'h0000_0010));
    s.push_back(mk(1'b0, 1'b1, 16'hFFFF, 1'b0, 26'h000, 32'h0000_000C));
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 26'h000, 32'h0000_0010));
    s.push_back(mk(1'b0, 1'b1, 16'hFFFB, 1'b0, 26'h000, 32'hFFFF_FFFC));
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 26'h000, 32'h0000_0000));
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 26'h000, 32'h0000_0004));
    foreach (s[i]) begin
      drive_cycle(s[i]);
      e = sbq.pop_front();
      checks++;
      if (inst_addr !== s[i].addr) begin
        failures++; $display("FAIL negwrap_addr[%0d] got %h want %h", i, inst_addr, s[i].addr);
      end
      checks++;
      if (ifid_inst !== e.inst || ifid_pc4 !== e.pc4 || ifid_valid !== e.valid) begin
        failures++; $display("FAIL negwrap_ifid[%0d] got %h/%h/%b want %h/%h/%b", i, ifid_inst, ifid_pc4, ifid_valid, e.inst, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_stall();
    step_t s[$];
    exp_t  e;
    for (int i = 0; i < 3; i++) s.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 26'h0, 32'h04));
    s.push_back(mk(1'b1, 1'b1, 16'h0004, 1'b0, 26'h0, 32'h14));
    s.push_back(mk(1'b1, 1'b1, 16'h0004, 1'b0, 26'h0, 32'h14));
    s.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 26'h0, 32'h18));
    foreach (s[i]) begin
      drive_cycle(s[i]);
      e = sbq.pop_front();
      checks++;
      if (inst_addr !== s[i].addr) begin
        failures++; $display("FAIL stall_addr[%0d] got %h want %h", i, inst_addr, s[i].addr);
      end
      checks++;
      if (ifid_inst !== e.inst || ifid_pc4 !== e.pc4 || ifid_valid !== e.valid) begin
        failures++; $display("FAIL stall_ifid[%0d] got %h/%h/%b want %h/%h/%b", i, ifid_inst, ifid_pc4, ifid_valid, e.inst, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t s[$];
    exp_t  e;
    stall = 1'b1; branch_taken = 1'b1; jump = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (inst_addr !== RST_PC || ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || ifid_pc4 !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got %h/%h/%h/%b want %h/0/0/0", inst_addr, ifid_inst, ifid_pc4, ifid_valid, RST_PC);
    end
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) s.push_back(mk(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, RST_PC + 32'((i + 1) * 4)));
    foreach (s[i]) begin
      drive_cycle(s[i]);
      e = sbq.pop_front();
      checks++;
      if (inst_addr !== s[i].addr) begin
        failures++; $display("FAIL restart_addr[%0d] got %h want %h", i, inst_addr, s[i].addr);
      end
      checks++;
      if (ifid_inst !== e.inst || ifid_pc4 !== e.pc4 || ifid_valid !== e.valid) begin
        failures++; $display("FAIL restart_ifid[%0d] got %h/%h/%b want %h/%h/%b", i, ifid_inst, ifid_pc4, ifid_valid, e.inst, e.pc4, e.valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_neg_wrap();
    test_stall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
